dmem_responder: RTL and testbench

- Data-memory responder serving load/store requests from the pipelined CPU's MEM stage over a valid/ready request channel and a valid/ready response channel.
- Replaces the fixed single-cycle BRAM data port with a configurable-latency responder, so that the CPU's stall logic can be exercised.
- Holds a word-addressed internal array and reports access errors.
- Keeps 16-bit read and write transaction counters for the debug path.

---
 rtl/dmem_if.sv | 24 ++
 rtl/dmem_responder.sv | 93 +++++++++
 tb/tb_dmem_responder.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Request/response channel between the CPU MEM stage and the data-memory responder.
// Both directions use a valid/ready handshake.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Configurable-latency data-memory responder: word array with byte-lane stores,
// access-error reporting and saturating load/store counters.
//
// state | meaning
// IDLE  | ready to accept one request
// WAIT  | counting down the remaining latency
// RESP  | response held until the CPU accepts it
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    dmem_if.slave       bus,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_wait;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic [15:0]           r_rd_count;
    logic [15:0]           r_wr_count;
    logic [31:0]           r_mem [2**ADDR_WIDTH];

    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_err;
    logic [ADDR_WIDTH-1:0] w_idx;

    assign w_req_ready = (r_state == IDLE) && !rst;
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_err       = (bus.req_addr[1:0] != 2'b00) ||
                         (bus.req_addr[31:ADDR_WIDTH+2] != '0);
    assign w_idx       = bus.req_addr[ADDR_WIDTH+1:2];

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
    assign rd_count       = r_rd_count;
    assign wr_count       = r_wr_count;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (r_wait == 4'd0) w_state_nxt = RESP;
            RESP:    if (bus.resp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wait     <= 4'd0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
            r_rd_count <= 16'd0;
            r_wr_count <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_wait <= LAT_M1;
                r_err  <= w_err;
                // Load data is snapshotted here so later stores cannot disturb it.
                r_rdata <= (w_err || bus.req_we) ? 32'd0 : r_mem[w_idx];
                if (bus.req_we) begin
                    if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
                end else begin
                    if (r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
                end
            end else if (r_state == WAIT && r_wait != 4'd0) begin
                r_wait <= r_wait - 4'd1;
            end
        end
    end

    // Array has no reset: contents survive rst, including stores just accepted.
    always_ff @(posedge clk) begin
        if (w_accept && bus.req_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req_wstrb[i]) r_mem[w_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: latency, byte strobes, errors, backpressure,
// mid-operation reset and counter saturation.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rd_count;
    logic [15:0] wr_count;
    int          errors = 0;
    int          checks = 0;
    int          exp_rd = 0;
    int          exp_wr = 0;

    dmem_if bus ();

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .rd_count (rd_count),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Issues one request and completes its response handshake; lat = -1 on timeout.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output logic err, output int lat);
        int n;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_wstrb  = strb;
        bus.resp_ready = 1'b0;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'hFFFF_FFFF;
        bus.req_wdata = 32'h5A5A_5A5A;
        lat = 0;
        while (!bus.resp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.resp_valid) lat = -1;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we = 1'b0;
        bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0;
        bus.req_wstrb = 4'h0;
        bus.resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_resp: valid=%b err=%b rdata=%h want 0/0/0", bus.resp_valid, bus.resp_err, bus.resp_rdata);
        end
        checks++;
        if (rd_count !== 16'd0 || wr_count !== 16'd0) begin
            errors++; $display("FAIL reset_counts: rd=%h wr=%h want 0/0", rd_count, wr_count);
        end
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready: got %b want 1", bus.req_ready); end
        exp_rd = 0;
        exp_wr = 0;
    endtask

    task automatic test_first_load();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        exp_rd++;
        checks++;
        if (lat != 3) begin errors++; $display("FAIL first_load_latency: got %0d want 3", lat); end
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL first_load_err: got %b want 0", er); end
        checks++;
        if (rd_count !== 16'(exp_rd)) begin errors++; $display("FAIL first_load_rd_count: got %h want %h", rd_count, 16'(exp_rd)); end
    endtask

    task automatic test_strobes();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, rd, er, lat);
        exp_wr++;
        checks++;
        if (rd !== 32'd0 || er !== 1'b0) begin errors++; $display("FAIL store_resp: rdata=%h err=%b want 0/0", rd, er); end
        do_req(1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, er, lat);
        exp_wr++;
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        exp_rd++;
        checks++;
        if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL strobe_lane0: got %h want DEADBEAA", rd); end
        checks++;
        if (wr_count !== 16'(exp_wr)) begin errors++; $display("FAIL strobe_wr_count: got %h want %h", wr_count, 16'(exp_wr)); end
        do_req(1'b1, 32'h10, 32'h11223344, 4'b0110, rd, er, lat);
        exp_wr++;
        do_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        exp_wr++;
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        exp_rd++;
        checks++;
        if (rd !== 32'hDE2233AA) begin errors++; $display("FAIL strobe_mid_lanes: got %h want DE2233AA", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1'b1, 32'h0, 32'h0BADF00D, 4'b1111, rd, er, lat);
        exp_wr++;
        do_req(1'b0, 32'h13, 32'h0, 4'h0, rd, er, lat);
        exp_rd++;
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL misaligned_load: err=%b rdata=%h want 1/0", er, rd); end
        do_req(1'b1, 32'h00001000, 32'hFFFFFFFF, 4'b1111, rd, er, lat);
        exp_wr++;
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL range_store: err=%b rdata=%h want 1/0", er, rd); end
        do_req(1'b1, 32'h2, 32'hFFFFFFFF, 4'b1111, rd, er, lat);
        exp_wr++;
        checks++;
        if (er !== 1'b1) begin errors++; $display("FAIL misaligned_store: err=%b want 1", er); end
        do_req(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        exp_rd++;
        checks++;
        if (rd !== 32'h0BADF00D || er !== 1'b0) begin errors++; $display("FAIL err_no_write: rdata=%h err=%b want 0BADF00D/0", rd, er); end
        checks++;
        if (rd_count !== 16'(exp_rd) || wr_count !== 16'(exp_wr)) begin
            errors++; $display("FAIL err_counts: rd=%h wr=%h want %h/%h", rd_count, wr_count, 16'(exp_rd), 16'(exp_wr));
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          bad;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we = 1'b0;
        bus.req_addr = 32'h10;
        bus.resp_ready = 1'b0;
        @(posedge clk);
        #1;
        exp_rd++;
        bus.req_addr = 32'h0;
        lat = 0;
        while (!bus.resp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != 3) begin errors++; $display("FAIL bp_latency: got %0d want 3", lat); end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hDE2233AA ||
                bus.resp_err !== 1'b0 || bus.req_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d unstable cycles, last valid=%b rdata=%h err=%b req_ready=%b want 1/DE2233AA/0/0",
                     bad, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.req_ready);
        end
        checks++;
        if (rd_count !== 16'(exp_rd)) begin errors++; $display("FAIL bp_no_accept: rd_count=%h want %h", rd_count, 16'(exp_rd)); end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rd_count !== 16'(exp_rd) || bus.resp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_handshake: rd_count=%h valid=%b want %h/0", rd_count, bus.resp_valid, 16'(exp_rd));
        end
        @(negedge clk);
        bus.resp_ready = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b want 1", bus.req_ready); end
        @(posedge clk);
        #1;
        exp_rd++;
        bus.req_valid = 1'b0;
        checks++;
        if (rd_count !== 16'(exp_rd)) begin errors++; $display("FAIL bp_next_accept: rd_count=%h want %h", rd_count, 16'(exp_rd)); end
        lat = 0;
        while (!bus.resp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = bus.resp_rdata;
        er = bus.resp_err;
        checks++;
        if (rd !== 32'h0BADF00D || er !== 1'b0) begin errors++; $display("FAIL bp_second_data: rdata=%h err=%b want 0BADF00D/0", rd, er); end
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          bad;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_addr = 32'h20;
        bus.req_wdata = 32'h12345678;
        bus.req_wstrb = 4'b1111;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
            errors++; $display("FAIL mid_reset_outputs: valid=%b req_ready=%b want 0/0", bus.resp_valid, bus.req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (rd_count !== 16'd0 || wr_count !== 16'd0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset_state: rd=%h wr=%h req_ready=%b want 0/0/1", rd_count, wr_count, bus.req_ready);
        end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL mid_reset_discard: resp_valid high %0d cycles want 0", bad); end
        exp_rd = 0;
        exp_wr = 0;
        do_req(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        exp_rd++;
        checks++;
        if (rd !== 32'h12345678 || er !== 1'b0) begin errors++; $display("FAIL mid_reset_store_kept: rdata=%h err=%b want 12345678/0", rd, er); end
        checks++;
        if (rd_count !== 16'(exp_rd)) begin errors++; $display("FAIL mid_reset_rd_count: got %h want %h", rd_count, 16'(exp_rd)); end
    endtask

    task automatic test_saturation();
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [15:0] exp_r [3];
        logic [15:0] exp_w [2];
        exp_r[0] = 16'hFFFE; exp_r[1] = 16'hFFFF; exp_r[2] = 16'hFFFF;
        exp_w[0] = 16'hFFFF; exp_w[1] = 16'hFFFF;
        @(negedge clk);
        force dut.r_rd_count = 16'hFFFD;
        force dut.r_wr_count = 16'hFFFE;
        #1;
        release dut.r_rd_count;
        release dut.r_wr_count;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
            checks++;
            if (rd_count !== exp_r[i]) begin errors++; $display("FAIL rd_saturate_%0d: got %h want %h", i, rd_count, exp_r[i]); end
        end
        for (int i = 0; i < 2; i++) begin
            do_req(1'b1, 32'h40, 32'h0, 4'h0, rd, er, lat);
            checks++;
            if (wr_count !== exp_w[i]) begin errors++; $display("FAIL wr_saturate_%0d: got %h want %h", i, wr_count, exp_w[i]); end
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.req_wstrb  = 4'h0;
        bus.resp_ready = 1'b0;
        test_reset();
        test_first_load();
        test_strobes();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
